pipe_stage_reg: RTL

//  Generic inter-stage pipeline register for the RISC-V core (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_sat_counter.sv | 36 +++
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types for the RISC-V inter-stage pipeline registers.
//   stage_st_e     : occupancy state of a pipe_stage_reg (EMPTY, FULL, SKID)
//   CTRL_BUBBLE    : control bit value carried by a bubble (all control zero)
//   id_ex_ctrl_t   : control bundle travelling ID -> EX ($bits gives CTRL_W)
//   ex_mem_ctrl_t  : control bundle travelling EX -> MEM
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_st_e;

    // One bit of the bubble pattern; replicated to the control width at use,
    // so a bubble deasserts every write enable further down the pipe.
    localparam logic CTRL_BUBBLE = 1'b0;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [4:0] alu_control;
        logic       alu_src;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// ---------------------------------------------------------------------------
// pipe_sat_counter
// Saturating event counter used for the pipeline statistics. Stops at
// all-ones instead of wrapping. Updates on the falling clock edge, like the
// pipeline registers it observes.
// Ports:
//   clk   in   1       pipeline clock (falling-edge active)
//   reset in   1       asynchronous active-high reset, clears the count
//   inc   in   1       count one event this cycle
//   clr   in   1       synchronous clear (takes priority over inc)
//   cnt   out  STAT_W  current count
// ---------------------------------------------------------------------------
module pipe_sat_counter #(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [STAT_W-1:0] cnt
);

    localparam logic [STAT_W-1:0] ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    // Count until all-ones, then hold there.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a
// valid/ready handshake. A second (skid) register absorbs the entry accepted
// in the cycle the downstream stalls, so in_ready is a pure function of the
// state register and back-pressure never ripples combinationally upstream.
// All state updates on the falling clock edge.
//
// Optional build macro PIPE_STAGE_STATS_EN adds the stall_cnt/flush_cnt
// statistics ports and their saturating counters.
//
// Ports:
//   clk        in   1       pipeline clock (falling-edge active)
//   reset      in   1       asynchronous active-high reset
//   flush      in   1       squash stage contents, dropping any offered entry
//   in_valid   in   1       upstream offers an entry
//   in_ready   out  1       stage can accept (registered)
//   in_data    in   DATA_W  upstream payload
//   in_ctrl    in   CTRL_W  upstream control bundle
//   out_valid  out  1       main register holds a valid entry
//   out_ready  in   1       downstream consumes this cycle
//   out_data   out  DATA_W  payload of the main register
//   out_ctrl   out  CTRL_W  control of the main register, bubble when invalid
//   stall_cnt  out  STAT_W  [PIPE_STAGE_STATS_EN] cycles stalled while valid
//   flush_cnt  out  STAT_W  [PIPE_STAGE_STATS_EN] flushes that discarded data
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 12
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int STAT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
`endif
);

    localparam int ENTRY_W = DATA_W + CTRL_W;

    stage_st_e            state_q, state_d;
    logic [ENTRY_W-1:0]   main_q, main_d;
    logic [ENTRY_W-1:0]   skid_q, skid_d;
    logic [ENTRY_W-1:0]   in_entry;

    assign in_entry  = {in_data, in_ctrl};
    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q[CTRL_W +: DATA_W];
    // main keeps its last payload after draining, so control is masked to
    // guarantee a bubble never carries a stale write enable.
    assign out_ctrl  = out_valid ? main_q[CTRL_W-1:0] : {CTRL_W{CTRL_BUBBLE}};

    // State and entry registers.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state: flush wins over everything; otherwise the handshake moves
    // entries main <- in, skid <- in (on a stall), main <- skid (on release).
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        main_d  = in_entry;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (in_valid && out_ready) begin
                        main_d = in_entry;
                    end else if (!in_valid && out_ready) begin
                        state_d = EMPTY;
                    end else if (in_valid && !out_ready) begin
                        skid_d  = in_entry;
                        state_d = SKID;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic stall_evt;
    logic flush_evt;

    // A flush counts when it throws away something valid: a held entry or
    // the entry being offered in the same cycle.
    assign stall_evt = out_valid && !out_ready;
    assign flush_evt = flush && (out_valid || in_valid);

    pipe_sat_counter #(.STAT_W(STAT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_evt),
        .clr   (1'b0),
        .cnt   (stall_cnt)
    );

    pipe_sat_counter #(.STAT_W(STAT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_evt),
        .clr   (1'b0),
        .cnt   (flush_cnt)
    );
`endif

endmodule
